// File: rtl/vga_scanout_if.sv
// Pixel-write interface between the game logic and the VGA scan-out.
//   x      : write column, 0..159 are in range
//   y      : write row, 0..119 are in range
//   colour : {R,G,B} colour to store
//   plot   : write strobe, sampled on every CLOCK_50 edge
//   ready  : high while the scan-out accepts writes
interface vga_scanout_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       ready;

  modport master (output x, y, colour, plot, input ready);
  modport slave  (input x, y, colour, plot, output ready);
endinterface

// File: rtl/vga_scanout.sv
// 160x120x3-bit framebuffer with 640x480@60 VGA scan-out. Each framebuffer
// cell is shown as a 4x4 block. After reset the buffer is swept to
// BACKGROUND (optional) before writes are accepted.
//   CLOCK_50, resetn : 50 MHz clock, asynchronous active-low reset
//   wr               : pixel-write interface (slave side)
//   VGA_R/G/B        : 8-bit colour, each channel 00 or FF
//   VGA_HS, VGA_VS   : active-low syncs
//   VGA_BLANK_N      : low outside the 640x480 visible area
//   VGA_SYNC_N       : constant 0
module vga_scanout #(
  parameter logic [2:0] BACKGROUND     = 3'b000,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  vga_scanout_if.slave  wr,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N
);

  localparam int          FB_CELLS  = 160 * 120;
  localparam logic [14:0] CLR_LAST  = 15'(FB_CELLS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  function automatic logic [23:0] expand_colour(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  state_t      state, state_next;
  logic [14:0] clr_addr, clr_addr_next;
  logic        ready_q;
  logic        we;
  logic [14:0] waddr;
  logic [2:0]  wdata;
  logic [14:0] plot_addr;
  logic        plot_in_range;

  assign plot_addr     = 15'(wr.y) * 15'd160 + 15'(wr.x);
  assign plot_in_range = (wr.x < 8'd160) && (wr.y < 7'd120);

  // ready is registered so it is low during reset regardless of the
  // reset state, and rises on the same edge the FSM enters RUN.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_addr <= 15'd0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
      ready_q  <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    we            = 1'b0;
    waddr         = 15'd0;
    wdata         = BACKGROUND;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr;
        if (clr_addr == CLR_LAST) begin
          state_next    = RUN;
          clr_addr_next = 15'd0;
        end else begin
          clr_addr_next = clr_addr + 15'd1;
        end
      end
      RUN: begin
        // Out-of-range coordinates are dropped rather than wrapped.
        if (wr.plot && plot_in_range) begin
          we    = 1'b1;
          waddr = plot_addr;
          wdata = wr.colour;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign wr.ready = ready_q;

  // ---- stage p0: pixel enable, timing counters, raw sync/blank, read address
  logic       pix_en;
  logic [9:0] hcnt, vcnt;
  logic       vis_p0, hs_p0, vs_p0;
  logic [14:0] rd_addr_p0;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pix_en <= 1'b0;
      hcnt   <= 10'd0;
      vcnt   <= 10'd0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcnt == 10'd799) begin
          hcnt <= 10'd0;
          vcnt <= (vcnt == 10'd524) ? 10'd0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  assign vis_p0 = (hcnt < 10'd640) && (vcnt < 10'd480);
  assign hs_p0  = !((hcnt >= 10'd656) && (hcnt <= 10'd751));
  assign vs_p0  = !((vcnt >= 10'd490) && (vcnt <= 10'd491));
  // Address is forced to 0 in blanking so the index never leaves the array.
  assign rd_addr_p0 = vis_p0 ? (15'(vcnt[9:2]) * 15'd160 + 15'(hcnt[9:2])) : 15'd0;

  // ---- stage p1: framebuffer (read returns old data on same-address write)
  logic [2:0] fb [0:FB_CELLS-1];
  logic [2:0] rd_colour_p1;

  always_ff @(posedge CLOCK_50) begin
    if (we) fb[waddr] <= wdata;
    rd_colour_p1 <= fb[rd_addr_p0];
  end

  // ---- stage p2: registered VGA outputs, one pixel tick behind the counters.
  // Read data captured on the non-tick edge belongs to the same counter
  // value as the raw syncs sampled here, so both line up.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
    end else if (pix_en) begin
      VGA_HS      <= hs_p0;
      VGA_VS      <= vs_p0;
      VGA_BLANK_N <= vis_p0;
      {VGA_R, VGA_G, VGA_B} <= vis_p0 ? expand_colour(rd_colour_p1) : 24'd0;
    end
  end

  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: expected pixels are queued by screen
// position, a negedge monitor checks sync/blank timing against an
// independent position model and pops queued pixels as they are scanned.
module tb_vga_scanout;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  vga_scanout_if wr();
  logic [7:0] vr, vg, vb;
  logic vhs, vvs, vbn, vsn;

  vga_scanout dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .wr          (wr),
    .VGA_R       (vr),
    .VGA_G       (vg),
    .VGA_B       (vb),
    .VGA_HS      (vhs),
    .VGA_VS      (vvs),
    .VGA_BLANK_N (vbn),
    .VGA_SYNC_N  (vsn)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int e = 0;  // CLOCK_50 edges since the last reset release

  always @(posedge clk or negedge resetn) begin
    if (!resetn) e <= 0;
    else         e <= e + 1;
  end

  typedef struct {
    int          pos;
    logic [23:0] rgb;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h (e=%0d)", name, act, exp, e);
    end
  endtask

  task automatic push(input int sx, input int sy, input logic [23:0] rgb);
    exp_t t;
    t.pos  = sy * 800 + sx;
    t.rgb  = rgb;
    t.name = $sformatf("pix_h%0d_v%0d", sx, sy);
    sb.push_back(t);
  endtask

  // Monitor: outputs after tick k (edge 2k) show counter value k-1.
  always @(negedge clk) begin : mon
    int k, pos, h, v;
    logic ehs, evs, ebn;
    k = e / 2;
    check("sync_n", 32'(vsn), 32'd0);
    if (k == 0) begin
      check("rst_hs", 32'(vhs), 32'd1);
      check("rst_vs", 32'(vvs), 32'd1);
      check("rst_blank_n", 32'(vbn), 32'd0);
      check("rst_rgb", 32'({vr, vg, vb}), 32'd0);
    end else begin
      pos = k - 1;
      h = pos % 800;
      v = (pos / 800) % 525;
      ehs = !(h >= 656 && h <= 751);
      evs = !(v >= 490 && v <= 491);
      ebn = (h < 640) && (v < 480);
      check("hs_timing", 32'(vhs), 32'(ehs));
      check("vs_timing", 32'(vvs), 32'(evs));
      check("blank_timing", 32'(vbn), 32'(ebn));
      if (!ebn) check("blank_rgb", 32'({vr, vg, vb}), 32'd0);
      if ((e % 2) == 0 && sb.size() > 0) begin
        if (sb[0].pos == pos) begin
          check(sb[0].name, 32'({vr, vg, vb}), 32'(sb[0].rgb));
          void'(sb.pop_front());
        end else if (sb[0].pos < pos) begin
          check({sb[0].name, "_missed"}, 32'(pos), 32'(sb[0].pos));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic do_plot(input int x, input int y, input int c);
    wr.x      = 8'(x);
    wr.y      = 7'(y);
    wr.colour = 3'(c);
    wr.plot   = 1'b1;
    @(negedge clk);
  endtask

  // Count cycles from release to ready; plot into the buffer while clearing.
  task automatic clear_phase(input string name);
    int cyc;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (wr.ready || cyc > 20000) break;
      check({name, "_ready_low"}, 32'(wr.ready), 32'd0);
      wr.plot = 1'b0;
      if (cyc == 100) begin
        wr.x = 8'd0; wr.y = 7'd0; wr.colour = 3'b100; wr.plot = 1'b1;
      end else if (cyc >= 19100) begin
        wr.x = 8'd10; wr.y = 7'd4; wr.colour = 3'b100; wr.plot = 1'b1;
      end
    end
    wr.plot = 1'b0;
    check(name, 32'(cyc), 32'd19200);
  endtask

  task automatic count_line();
    int hl, bh;
    hl = 0; bh = 0;
    repeat (1600) begin
      @(negedge clk);
      if (!vhs) hl++;
      if (vbn)  bh++;
    end
    check("hs_low_per_line", 32'(hl), 32'd192);
    check("blank_high_per_line", 32'(bh), 32'd1280);
  endtask

  int          hlist [10] = '{19, 20, 23, 24, 31, 32, 35, 36, 39, 40};
  logic [23:0] clist [10] = '{24'h000000, 24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000,
                             24'h00FF00, 24'h00FF00, 24'hFF0000, 24'hFF0000, 24'h000000};

  initial begin
    int guard;
    wr.x = 8'd0; wr.y = 7'd0; wr.colour = 3'd0; wr.plot = 1'b0;

    // Expected screen after the first clear plus the plot sequence below.
    for (int sy = 12; sy <= 15; sy++)
      for (int i = 0; i < 10; i++) push(hlist[i], sy, clist[i]);
    push(0, 16, 24'h000000);    // cell (0,4)
    push(40, 16, 24'h000000);   // cell (10,4), plotted only during CLEAR
    push(380, 16, 24'h000000);  // alias target of x=255,y=3
    push(0, 20, 24'h000000);    // alias target of x=160,y=4
    push(3, 20, 24'h000000);

    repeat (3) @(negedge clk);
    check("reset_ready", 32'(wr.ready), 32'd0);
    resetn = 1'b1;

    clear_phase("ready_latency_1");

    do_plot(5, 3, 3'b001);
    do_plot(160, 4, 3'b111);
    do_plot(255, 3, 3'b111);
    do_plot(0, 120, 3'b111);
    do_plot(8, 3, 3'b010);
    do_plot(9, 3, 3'b100);
    wr.plot = 1'b0;
    check("ready_in_run", 32'(wr.ready), 32'd1);

    repeat (3) count_line();

    // Drive to mid-line (h~300) of line 24, then reset asynchronously.
    guard = 0;
    while (e < 2 * (24 * 800 + 300) && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    check("reached_midframe", 32'(e >= 2 * (24 * 800 + 300)), 32'd1);
    check("pre_reset_blank_n", 32'(vbn), 32'd1);
    #3 resetn = 1'b0;
    #1;
    check("async_hs", 32'(vhs), 32'd1);
    check("async_vs", 32'(vvs), 32'd1);
    check("async_blank_n", 32'(vbn), 32'd0);
    check("async_rgb", 32'({vr, vg, vb}), 32'd0);
    check("async_ready", 32'(wr.ready), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Second clear must wipe the plotted cells.
    push(20, 12, 24'h000000);
    push(32, 12, 24'h000000);
    push(36, 12, 24'h000000);
    clear_phase("ready_latency_2");

    guard = 0;
    while (sb.size() > 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Receiving end of the pixel-write interface the game top drives: x, y, colour and plot.
- Holds a 160x120 framebuffer with 3-bit colour per pixel.
- Generates 640x480@60 VGA timing from CLOCK_50 using a divide-by-2 pixel enable.
- Each framebuffer pixel is shown as a 4x4 block on screen.
- After reset it clears the framebuffer to the background colour before accepting writes.

Parameters:
- BACKGROUND, 3'b000: colour written to every cell during the clear sweep.
- CLEAR_ON_RESET, 1: 1 = run the clear sweep after reset; 0 = go straight to RUN, framebuffer contents undefined.

Ports:
- CLOCK_50  in  1  50 MHz system clock
- resetn  in  1  asynchronous, active-low reset
- x  in  8  write column, valid 0..159
- y  in  7  write row, valid 0..119
- colour  in  3  {R,G,B} write colour
- plot  in  1  write strobe, sampled every CLOCK_50 cycle
- ready  out  1  high when writes are accepted (RUN state)
- VGA_R  out  8  red
- VGA_G  out  8  green
- VGA_B  out  8  blue
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  low outside the visible area
- VGA_SYNC_N  out  1  tied 0

Behaviour:
- Reset is asynchronous and active low, on CLOCK_50. While resetn=0:
  - pix_en=0, hcnt=0, vcnt=0, clear address=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0.
  - ready=0; state=CLEAR if CLEAR_ON_RESET, else RUN.
- Pixel enable: pix_en toggles every CLOCK_50 cycle. Counters and output registers update only on cycles where pix_en=1; the first such cycle is the second edge after reset release.
- Horizontal counter hcnt runs 0..799 and wraps to 0.
  - visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical counter vcnt increments when hcnt wraps; runs 0..524 and wraps to 0.
  - visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Read address = (vcnt>>2)*160 + (hcnt>>2), 15 bits. It is computed only in the visible area; outside it, the address is don't-care.
- Framebuffer: 19200 x 3 bits, synchronous read and synchronous write, one of each per CLOCK_50 cycle.
  - A read and write to the same address in the same cycle returns the old data.
- Output pipeline: all VGA outputs are registered and lag the counter position by exactly one pixel tick.
  - Raw HS/VS/blank are delayed one pixel tick so they stay aligned with read data.
  - Output at pixel tick n reflects counter values from tick n-1.
- Colour expansion: each colour bit maps to 8'hFF if set, 8'h00 if clear (bit2→R, bit1→G, bit0→B). RGB is forced to 0 whenever the delayed blank is active.
- State machine:
  - CLEAR:
    - Writes BACKGROUND to address clr_addr each CLOCK_50 cycle.
    - clr_addr increments 0→19199; exit to RUN on the cycle after writing 19199, i.e. 19200 cycles in CLEAR.
    - plot is ignored and ready=0.
    - Scan-out keeps running in CLEAR and displays whatever memory returns.
  - RUN:
    - ready=1.
    - When plot=1, x<160 and y<120: write colour to address y*160+x on that edge. The written data is visible to reads from the next cycle.
    - When plot=1 with x>=160 or y>=120: the write is dropped with no aliasing, and no other address changes.
    - Back-to-back plots every cycle are all accepted.
- Reset mid-operation (mid-frame or mid-clear): outputs return to reset values immediately; the clear restarts from address 0 after release.
- VGA_SYNC_N is constant 0. No backpressure: a write in RUN never stalls scan-out.

Test Plan:
- Reset release, CLEAR_ON_RESET=1 → ready rises exactly 19200 CLOCK_50 cycles after release; all visible pixels read RGB=0 in the first full frame after ready.
- Free-run 2 frames →
  - HS low exactly 192 CLOCK_50 cycles per 1600-cycle line.
  - VS low for exactly 2 lines per 525.
  - BLANK_N high for 1280 cycles per line and 480 lines per frame.
  - Sync edges align to hcnt/vcnt values +1 pixel tick.
- Plot x=5, y=3, colour=3'b001 in RUN → screen pixels h 20..23, v 12..15 show R=0, G=0, B=FF in the next frame; neighbours h=19 and h=24 stay black.
- Plot x=160, y=0, colour=3'b111 and plot x=0, y=120, colour=3'b111 → no visible pixel changes, including x=0,y=1 and x=0,y=0.
- Plot during CLEAR (colour 3'b100 at x=0, y=0) → ignored; pixel 0,0 shows BACKGROUND after ready.
- Assert resetn low at hcnt≈300, vcnt≈200 → HS=VS=1, BLANK_N=0, RGB=0 asynchronously; after release ready=0 and the clear re-runs for 19200 cycles.
